// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with imem req/ack, redirect flush and skid buffer; optional MISALIGN_CHK_EN
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            misalign_err
);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, ERR} state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state, state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_addr, req_addr_d;
    logic [XLEN-1:0] if_pc_d;
    logic [XLEN-1:0] skid_pc, skid_pc_d;
    logic [31:0]     if_instr_d;
    logic [31:0]     skid_instr, skid_instr_d;
    logic            if_valid_d;
    logic            out_free;

`ifdef MISALIGN_CHK_EN
    logic err_q, err_d;
`endif

    assign pc_plus4  = pc + XLEN'(4);
    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = req_addr;
    // The output register can take new data when it is empty or decode takes it this cycle.
    assign out_free  = !if_valid || !stall;

    // Next-state and next-datapath values; every target defaults to holding its current value.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_addr_d   = req_addr;
        if_valid_d   = if_valid;
        if_instr_d   = if_instr;
        if_pc_d      = if_pc;
        skid_instr_d = skid_instr;
        skid_pc_d    = skid_pc;

        case (state)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    state_d    = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    pc_d = next_pc;
                    if (out_free) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = req_addr;
                        if_valid_d = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = req_addr;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d       = next_pc;
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (!stall) begin
                    if_instr_d = skid_instr;
                    if_pc_d    = skid_pc;
                    if_valid_d = 1'b1;
                    state_d    = REQ;
                end
            end
            DROP: begin
                // The stale request must complete; once acked, a redirect arriving in
                // the same cycle simply becomes the address of the fresh request.
                if (redirect) begin
                    pc_d = next_pc;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
            end
        endcase

`ifdef MISALIGN_CHK_EN
        // pc only ever becomes misaligned through a load of next_pc, so checking the
        // next pc value catches every offending load (RESET_PC is assumed aligned).
        err_d = err_q | (pc_d[1:0] != 2'b00);
        if (err_d && (state_d != DROP)) begin
            state_d    = ERR;
            if_valid_d = 1'b0;
            pc_d       = (state == ERR) ? pc : pc_d;
        end
`endif

        // A fresh request starts whenever REQ is entered or re-entered after an ack.
        if ((state_d == REQ) && ((state != REQ) || imem_ack)) begin
            req_addr_d = pc_d & ALIGN_MASK;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // PC, request address, decode output and skid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            pc         <= pc_d;
            req_addr   <= req_addr_d;
            if_valid   <= if_valid_d;
            if_instr   <= if_instr_d;
            if_pc      <= if_pc_d;
            skid_instr <= skid_instr_d;
            skid_pc    <= skid_pc_d;
        end
    end

`ifdef MISALIGN_CHK_EN
    // Sticky misaligned-PC flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule
